// File: rtl/minivan_pkg.sv
// Shared frame constants and FSM state type for the minivan SPI register interface.
package minivan_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_CMD_BITS   = 8;
  localparam int SPI_RW_BIT     = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/minivan_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, plus registered rise/fall pulses.
module minivan_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: non-blocking assignments so each flop samples the value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level = sync_q[STAGES-1];

endmodule

// File: rtl/minivan_spi_regif.sv
// SPI mode-0 slave that turns 16-bit frames into single-cycle register read/write strobes.
module minivan_spi_regif
  import minivan_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  localparam int CNT_W   = 5;
  localparam int FLUSH   = SYNC_STAGES + 3;
  localparam int FLUSH_W = $clog2(FLUSH + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  minivan_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(spi_sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  minivan_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(spi_cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  state_t                  state, state_next;
  logic [CNT_W-1:0]        bit_cnt;
  logic [SPI_CMD_BITS-2:0] rx;
  logic [SPI_CMD_BITS-1:0] rx_next;
  logic [DATA_W-1:0]       tx;
  logic                    rw_q, load_pend, oe_q, armed;
  logic [FLUSH_W-1:0]      flush_cnt;
  logic                    flush_done;
  logic clr_cnt, do_shift, cmd_done, data_done, abort, end_frame, tx_shift, tx_load;

  assign rx_next    = {rx, mosi_s};
  assign flush_done = (flush_cnt == FLUSH_W'(FLUSH));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    clr_cnt    = 1'b0;
    do_shift   = 1'b0;
    cmd_done   = 1'b0;
    data_done  = 1'b0;
    abort      = 1'b0;
    end_frame  = 1'b0;
    tx_shift   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          clr_cnt    = 1'b1;
          state_next = CMD;
        end
      end
      CMD: begin
        if (cs_rise) begin
          end_frame  = 1'b1;
          abort      = (bit_cnt != '0);
          state_next = IDLE;
        end else if (sclk_rise) begin
          do_shift = 1'b1;
          if (bit_cnt == CNT_W'(SPI_CMD_BITS - 1)) begin
            cmd_done   = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        // The first fall after the command byte precedes the data phase; only later falls shift.
        tx_shift = sclk_fall && (bit_cnt > CNT_W'(SPI_CMD_BITS));
        if (cs_rise) begin
          end_frame  = 1'b1;
          abort      = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise) begin
          do_shift = 1'b1;
          if (bit_cnt == CNT_W'(SPI_FRAME_BITS - 1)) begin
            data_done  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (cs_rise) begin
          end_frame  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_load = load_pend && (state != IDLE) && !end_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      rw_q      <= 1'b0;
      load_pend <= 1'b0;
      oe_q      <= 1'b0;
      armed     <= 1'b0;
      flush_cnt <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= abort;
      load_pend <= reg_rd_en;

      // Reset values ripple through the synchronisers; only trust cs_n once they have flushed
      // and the bus has been seen idle, so a cs_n held low across reset starts nothing.
      if (!flush_done)              flush_cnt <= flush_cnt + FLUSH_W'(1);
      else if (cs_lvl && !sclk_lvl) armed     <= 1'b1;

      if (clr_cnt)       bit_cnt <= '0;
      else if (do_shift) bit_cnt <= bit_cnt + CNT_W'(1);
      if (do_shift)      rx      <= rx_next[SPI_CMD_BITS-2:0];

      if (cmd_done) begin
        reg_addr  <= rx_next[ADDR_W-1:0];
        rw_q      <= rx_next[SPI_RW_BIT - SPI_CMD_BITS];
        reg_rd_en <= rx_next[SPI_RW_BIT - SPI_CMD_BITS];
      end
      if (data_done && !rw_q) begin
        reg_wdata <= rx_next[DATA_W-1:0];
        reg_wr_en <= 1'b1;
      end

      if (tx_load) begin
        tx   <= reg_rdata;
        oe_q <= 1'b1;
      end else if (tx_shift) begin
        tx   <= {tx[DATA_W-2:0], 1'b0};
      end
      if (end_frame) oe_q <= 1'b0;
    end
  end

  assign spi_miso_oe = oe_q;
  assign spi_miso    = oe_q & tx[DATA_W-1];

endmodule

// File: tb/tb_minivan_spi_regif.sv
// Self-checking bench: an SPI master model drives frames; a frame-level reference predicts strobes, errors and read data.
module tb_minivan_spi_regif;

  localparam int SYNC_STAGES = 2;
  localparam int HMIN        = SYNC_STAGES + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en, reg_rd_en, frame_err;
  logic [7:0] reg_rdata = 8'h00;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit         rd;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        ev_q[$];
  ev_t        exp_q[$];
  int         err_cnt  = 0;
  int         oe_cnt   = 0;
  int         both_cnt = 0;
  logic [7:0] seed_byte;
  bit         core_written[128];
  logic [7:0] core_mem[128];
  logic [7:0] ref_mem[128];
  bit         oe_end;

  minivan_spi_regif #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [6:0] a);
    if (a == 7'h05) return 8'h3C;
    return (8'({1'b0, a}) * 8'd37) ^ seed_byte;
  endfunction

  // Core register file: read data appears the cycle after reg_rd_en.
  always @(posedge clk) begin
    if (reg_rd_en) reg_rdata <= core_written[reg_addr] ? core_mem[reg_addr] : init_val(reg_addr);
    if (reg_wr_en) begin
      core_mem[reg_addr]     <= reg_wdata;
      core_written[reg_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reg_wr_en) ev_q.push_back('{rd: 1'b0, addr: reg_addr, data: reg_wdata});
    if (reg_rd_en) ev_q.push_back('{rd: 1'b1, addr: reg_addr, data: 8'h00});
    if (reg_wr_en && reg_rd_en) both_cnt++;
    if (frame_err) err_cnt++;
    if (spi_miso_oe) oe_cnt++;
  end

  // Frame-level reference: bits[23] is the first bit on the wire.
  task automatic model_frame(input logic [23:0] bits, input int n,
                             output bit exp_err, output logic [7:0] exp_miso, output bit full_read);
    logic [7:0] cmd;
    logic [7:0] dat;
    cmd       = bits[23:16];
    dat       = bits[15:8];
    exp_err   = (n > 0) && (n < 16);
    full_read = cmd[7] && (n >= 16);
    exp_miso  = ref_mem[cmd[6:0]];
    if (n >= 8 && cmd[7]) exp_q.push_back('{rd: 1'b1, addr: cmd[6:0], data: 8'h00});
    if (n >= 16 && !cmd[7]) begin
      exp_q.push_back('{rd: 1'b0, addr: cmd[6:0], data: dat});
      ref_mem[cmd[6:0]] = dat;
    end
  endtask

  task automatic send_bits(input logic [23:0] bits, input int n, input int h, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[23-i];
      repeat (h) @(negedge clk);
      if (i >= 8 && i < 16) miso_b = {miso_b[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (h) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [23:0] bits, input int n, input int h, input int gap,
                           output logic [7:0] miso_b);
    spi_cs_n = 1'b0;
    repeat (h) @(negedge clk);
    send_bits(bits, n, h, miso_b);
    repeat (h) @(negedge clk);
    oe_end   = spi_miso_oe;
    spi_cs_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({reg_addr, reg_wdata, reg_wr_en, reg_rd_en, frame_err, spi_miso, spi_miso_oe} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {reg_addr, reg_wdata, reg_wr_en, reg_rd_en, frame_err, spi_miso, spi_miso_oe});
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if ({reg_addr, reg_wdata, spi_miso_oe} !== 16'd0 || ev_q.size() != 0 || err_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_release: addr %h wdata %h oe %b events %0d errs %0d, expected all 0",
               reg_addr, reg_wdata, spi_miso_oe, ev_q.size(), err_cnt);
    end
  endtask

  task automatic test_write();
    int eb, er, oe0;
    bit xe, fr;
    logic [7:0] xm, m;
    eb = ev_q.size(); er = err_cnt; oe0 = oe_cnt;
    model_frame(24'h12A500, 16, xe, xm, fr);
    spi_frame(24'h12A500, 16, HMIN, 12, m);
    vectors++;
    if (ev_q.size() != eb + 1) begin
      miscompares++; $display("FAIL write_count: got %0d strobes expected 1", ev_q.size() - eb);
    end
    vectors++;
    if (ev_q[eb].rd !== 1'b0 || ev_q[eb].addr !== 7'h12 || ev_q[eb].data !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_strobe: got rd=%b addr %h data %h expected write 12/a5",
               ev_q[eb].rd, ev_q[eb].addr, ev_q[eb].data);
    end
    vectors++;
    if (err_cnt != er || oe_cnt != oe0) begin
      miscompares++;
      $display("FAIL write_err_oe: got %0d errs %0d oe cycles expected 0/0", err_cnt - er, oe_cnt - oe0);
    end
    vectors++;
    if (reg_addr !== 7'h12 || reg_wdata !== 8'hA5) begin
      miscompares++; $display("FAIL write_hold: got %h/%h expected 12/a5", reg_addr, reg_wdata);
    end
  endtask

  task automatic test_read();
    int eb, er;
    bit xe, fr;
    logic [7:0] xm, m;
    eb = ev_q.size(); er = err_cnt;
    model_frame(24'h850000, 16, xe, xm, fr);
    spi_frame(24'h850000, 16, HMIN, 12, m);
    vectors++;
    if (ev_q.size() != eb + 1 || ev_q[eb].rd !== 1'b1 || ev_q[eb].addr !== 7'h05) begin
      miscompares++;
      $display("FAIL read_strobe: got %0d strobes rd=%b addr %h expected one read of 05",
               ev_q.size() - eb, ev_q[eb].rd, ev_q[eb].addr);
    end
    vectors++;
    if (m !== 8'h3C) begin
      miscompares++; $display("FAIL read_miso: got %h expected 3c", m);
    end
    vectors++;
    if (oe_end !== 1'b1 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
      miscompares++;
      $display("FAIL read_oe: oe before cs rise %b, after %b, miso after %b; expected 1,0,0",
               oe_end, spi_miso_oe, spi_miso);
    end
    vectors++;
    if (err_cnt != er) begin
      miscompares++; $display("FAIL read_err: got %0d expected 0", err_cnt - er);
    end
  endtask

  task automatic test_truncated();
    int eb, er;
    bit xe, fr;
    logic [7:0] xm, m;
    eb = ev_q.size(); er = err_cnt;
    model_frame(24'h40AB00, 11, xe, xm, fr);
    spi_frame(24'h40AB00, 11, HMIN, 12, m);
    vectors++;
    if (ev_q.size() != eb || err_cnt != er + 1) begin
      miscompares++;
      $display("FAIL truncated: got %0d strobes %0d errs expected 0 strobes 1 err", ev_q.size() - eb, err_cnt - er);
    end
    model_frame(24'h01FF00, 16, xe, xm, fr);
    spi_frame(24'h01FF00, 16, HMIN, 12, m);
    vectors++;
    if (ev_q.size() != eb + 1 || ev_q[eb].rd !== 1'b0 || ev_q[eb].addr !== 7'h01 ||
        ev_q[eb].data !== 8'hFF || err_cnt != er + 1) begin
      miscompares++;
      $display("FAIL after_truncated: got %0d strobes addr %h data %h expected write 01/ff",
               ev_q.size() - eb, ev_q[eb].addr, ev_q[eb].data);
    end
  endtask

  task automatic test_overlength();
    int eb, er;
    bit xe, fr;
    logic [7:0] xm, m;
    eb = ev_q.size(); er = err_cnt;
    model_frame(24'h2055A0, 20, xe, xm, fr);
    spi_frame(24'h2055A0, 20, HMIN, 12, m);
    vectors++;
    if (ev_q.size() != eb + 1 || ev_q[eb].rd !== 1'b0 || ev_q[eb].addr !== 7'h20 ||
        ev_q[eb].data !== 8'h55 || err_cnt != er) begin
      miscompares++;
      $display("FAIL overlength: got %0d strobes addr %h data %h errs %0d expected one write 20/55 no err",
               ev_q.size() - eb, ev_q[eb].addr, ev_q[eb].data, err_cnt - er);
    end
  endtask

  task automatic test_reset_midframe();
    int eb, er;
    bit xe, fr;
    logic [7:0] xm, m;
    logic [23:0] bits, rest;
    eb = ev_q.size(); er = err_cnt;
    bits = 24'h6BC300;
    rest = bits << 6;
    spi_cs_n = 1'b0;
    repeat (HMIN) @(negedge clk);
    send_bits(bits, 6, HMIN, m);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({reg_addr, reg_wdata, reg_wr_en, reg_rd_en, frame_err, spi_miso, spi_miso_oe} !== 20'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h expected 0",
               {reg_addr, reg_wdata, reg_wr_en, reg_rd_en, frame_err, spi_miso, spi_miso_oe});
    end
    rst = 1'b0;
    send_bits(rest, 10, HMIN, m);
    repeat (HMIN) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    vectors++;
    if (ev_q.size() != eb || err_cnt != er || reg_addr !== 7'h00 || reg_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_ignore: got %0d strobes %0d errs addr %h wdata %h expected none, 00/00",
               ev_q.size() - eb, err_cnt - er, reg_addr, reg_wdata);
    end
    model_frame(24'h339C00, 16, xe, xm, fr);
    spi_frame(24'h339C00, 16, HMIN, 12, m);
    vectors++;
    if (ev_q.size() != eb + 1 || ev_q[eb].addr !== 7'h33 || ev_q[eb].data !== 8'h9C || ev_q[eb].rd !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_recover: got %0d strobes addr %h data %h expected write 33/9c",
               ev_q.size() - eb, ev_q[eb].addr, ev_q[eb].data);
    end
  endtask

  task automatic test_back_to_back();
    int eb, er;
    bit xe, fr;
    logic [7:0] xm1, xm2, m1, m2;
    eb = ev_q.size(); er = err_cnt;
    model_frame(24'h810000, 16, xe, xm1, fr);
    spi_frame(24'h810000, 16, HMIN, SYNC_STAGES + 3, m1);
    model_frame(24'h017700, 16, xe, xm2, fr);
    spi_frame(24'h017700, 16, HMIN, 12, m2);
    vectors++;
    if (ev_q.size() != eb + 2 || ev_q[eb].rd !== 1'b1 || ev_q[eb].addr !== 7'h01 ||
        ev_q[eb+1].rd !== 1'b0 || ev_q[eb+1].addr !== 7'h01 || ev_q[eb+1].data !== 8'h77) begin
      miscompares++;
      $display("FAIL b2b_order: got %0d strobes, first rd=%b addr %h, second rd=%b %h/%h expected read 01 then write 01/77",
               ev_q.size() - eb, ev_q[eb].rd, ev_q[eb].addr, ev_q[eb+1].rd, ev_q[eb+1].addr, ev_q[eb+1].data);
    end
    vectors++;
    if (m1 !== xm1 || err_cnt != er) begin
      miscompares++; $display("FAIL b2b_read: got miso %h errs %0d expected %h, 0", m1, err_cnt - er, xm1);
    end
  endtask

  task automatic test_random();
    int eb, ebx, er, n, h, r;
    bit xe, fr;
    logic [7:0] xm, m;
    logic [23:0] bits;
    for (int it = 0; it < 24; it++) begin
      bits = 24'($urandom);
      r    = $urandom_range(0, 9);
      if (r < 6)       n = 16;
      else if (r == 6) n = $urandom_range(17, 20);
      else             n = $urandom_range(0, 15);
      h   = $urandom_range(HMIN, 8);
      eb  = ev_q.size(); ebx = exp_q.size(); er = err_cnt;
      model_frame(bits, n, xe, xm, fr);
      spi_frame(bits, n, h, 12, m);
      vectors++;
      if (ev_q.size() - eb != exp_q.size() - ebx) begin
        miscompares++;
        $display("FAIL rand_count[%0d]: got %0d strobes expected %0d (frame %h, %0d bits)",
                 it, ev_q.size() - eb, exp_q.size() - ebx, bits, n);
      end
      for (int k = 0; k < exp_q.size() - ebx; k++) begin
        vectors++;
        if (ev_q[eb+k].rd !== exp_q[ebx+k].rd || ev_q[eb+k].addr !== exp_q[ebx+k].addr ||
            ev_q[eb+k].data !== exp_q[ebx+k].data) begin
          miscompares++;
          $display("FAIL rand_strobe[%0d]: got rd=%b %h/%h expected rd=%b %h/%h", it,
                   ev_q[eb+k].rd, ev_q[eb+k].addr, ev_q[eb+k].data,
                   exp_q[ebx+k].rd, exp_q[ebx+k].addr, exp_q[ebx+k].data);
        end
      end
      vectors++;
      if ((err_cnt - er) != int'(xe)) begin
        miscompares++; $display("FAIL rand_err[%0d]: got %0d expected %0d", it, err_cnt - er, xe);
      end
      if (fr) begin
        vectors++;
        if (m !== xm) begin
          miscompares++; $display("FAIL rand_miso[%0d]: got %h expected %h", it, m, xm);
        end
      end
      if (n >= 8) begin
        vectors++;
        if (reg_addr !== bits[22:16]) begin
          miscompares++; $display("FAIL rand_addr[%0d]: got %h expected %h", it, reg_addr, bits[22:16]);
        end
      end
    end
    vectors++;
    if (both_cnt != 0) begin
      miscompares++; $display("FAIL both_strobes: got %0d cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    seed_byte = 8'($urandom);
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(7'(i));
    test_reset();
    test_write();
    test_read();
    test_truncated();
    test_overlength();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
